// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch controller: PC width, default
// vectors and the 2-bit FSM state encoding.
package if_pkg;

   localparam int PC_W = 16;

   localparam logic [PC_W-1:0] RESET_VEC_DFLT = 16'h0000;
   localparam logic [PC_W-1:0] IRQ_VEC_DFLT   = 16'h0010;

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_IRQ_SAVE = 2'd2,
      ST_IRQ_JUMP = 2'd3
   } state_e;

   typedef struct packed {
      logic            load_pc;
      logic [PC_W-1:0] pc_in;
      logic            pc_en;
      logic            flush;
      logic            irq_ack;
   } ctrl_t;

endpackage

// File: rtl/if_ctrl.sv
// Fetch-stage controller: boot load, redirect arbitration, stall and interrupt
// entry/return. Interrupt support is compiled in only when IF_CTRL_IRQ_EN is defined.
//
// state       | meaning (action taken at the next rising edge)
// ST_BOOT     | emit load of RESET_VEC, go to RUN
// ST_RUN      | arbitrate irq > iret > jump > branch > stall > sequential
// ST_IRQ_SAVE | flush showing, epc saved; emit IRQ_VEC load + ack, set in_isr
// ST_IRQ_JUMP | vector load showing; emit sequential advance, back to RUN
module if_ctrl
   import if_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VEC = RESET_VEC_DFLT,
   parameter logic [PC_W-1:0] IRQ_VEC   = IRQ_VEC_DFLT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] pc,
   input  logic            stall,
   input  logic            jump_req,
   input  logic [PC_W-1:0] jump_target,
   input  logic            branch_req,
   input  logic [PC_W-1:0] branch_target,
   input  logic            irq_req,
   input  logic            iret_req,
   output logic            load_pc,
   output logic [PC_W-1:0] pc_in,
   output logic            pc_en,
   output logic            flush,
   output logic            irq_ack,
   output logic            in_isr,
   output logic [PC_W-1:0] epc
);

   state_e          state_q, state_d;
   ctrl_t           out_q, out_d;
   logic            in_isr_q, in_isr_d;
   logic [PC_W-1:0] epc_q, epc_d;
   logic            irq_go, iret_go;
   logic            redir_go;
   logic [PC_W-1:0] redir_tgt;
   logic [PC_W-1:0] irq_epc;

`ifdef IF_CTRL_IRQ_EN
   assign irq_go  = irq_req && !in_isr_q;
   assign iret_go = iret_req && in_isr_q;
`else
   assign irq_go  = 1'b0;
   assign iret_go = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_BOOT;
         out_q    <= '{load_pc: 1'b0, pc_in: RESET_VEC, pc_en: 1'b0,
                       flush: 1'b0, irq_ack: 1'b0};
         in_isr_q <= 1'b0;
         epc_q    <= '0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         in_isr_q <= in_isr_d;
         epc_q    <= epc_d;
      end
   end

   // A redirect racing an interrupt entry is preserved by saving its target as epc.
   always_comb begin
      redir_go  = 1'b1;
      redir_tgt = jump_target;
      if (iret_go)         redir_tgt = epc_q;
      else if (jump_req)   redir_tgt = jump_target;
      else if (branch_req) redir_tgt = branch_target;
      else                 redir_go  = 1'b0;
      irq_epc = jump_req ? jump_target : (branch_req ? branch_target : pc);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT:     state_d = ST_RUN;
         ST_RUN:      state_d = irq_go ? ST_IRQ_SAVE : ST_RUN;
`ifdef IF_CTRL_IRQ_EN
         ST_IRQ_SAVE: state_d = ST_IRQ_JUMP;
         ST_IRQ_JUMP: state_d = ST_RUN;
`endif
         default:     state_d = ST_BOOT;
      endcase
   end

   always_comb begin
      out_d         = out_q;
      out_d.load_pc = 1'b0;
      out_d.pc_en   = 1'b0;
      out_d.flush   = 1'b0;
      out_d.irq_ack = 1'b0;
      in_isr_d      = in_isr_q;
      epc_d         = epc_q;
      case (state_q)
         ST_BOOT: begin
            out_d.load_pc = 1'b1;
            out_d.pc_in   = RESET_VEC;
         end
         ST_RUN: begin
            if (irq_go) begin
               out_d.flush = 1'b1;
               epc_d       = irq_epc;
            end else if (redir_go) begin
               out_d.load_pc = 1'b1;
               out_d.flush   = 1'b1;
               out_d.pc_in   = redir_tgt;
               if (iret_go) in_isr_d = 1'b0;
            end else if (!stall) begin
               out_d.pc_en = 1'b1;
            end
         end
`ifdef IF_CTRL_IRQ_EN
         ST_IRQ_SAVE: begin
            out_d.load_pc = 1'b1;
            out_d.pc_in   = IRQ_VEC;
            out_d.irq_ack = 1'b1;
            in_isr_d      = 1'b1;
         end
         ST_IRQ_JUMP: out_d.pc_en = 1'b1;
`endif
         default: ;
      endcase
   end

   assign load_pc = out_q.load_pc;
   assign pc_in   = out_q.pc_in;
   assign pc_en   = out_q.pc_en;
   assign flush   = out_q.flush;

`ifdef IF_CTRL_IRQ_EN
   assign irq_ack = out_q.irq_ack;
   assign in_isr  = in_isr_q;
   assign epc     = epc_q;
`else
   logic unused_irq;
   assign unused_irq = ^{pc, irq_req, iret_req, IRQ_VEC, out_q.irq_ack};
   assign irq_ack = 1'b0;
   assign in_isr  = 1'b0;
   assign epc     = '0;
`endif

endmodule

// File: tb/tb_if_ctrl.sv
// Self-checking bench for if_ctrl: directed table, hand-written corner sequences
// and random stimulus against a behavioural model of the fetch-control rules.
module tb_if_ctrl;

`ifdef IF_CTRL_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif
   localparam logic [15:0] RVEC = 16'h0000;
   localparam logic [15:0] IVEC = 16'h0010;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] pc = '0;
   logic        stall = 1'b0, jump_req = 1'b0, branch_req = 1'b0;
   logic [15:0] jump_target = '0, branch_target = '0;
   logic        irq_req = 1'b0, iret_req = 1'b0;
   logic        load_pc, pc_en, flush, irq_ack, in_isr;
   logic [15:0] pc_in, epc;

   int vectors = 0;
   int miscompares = 0;

   if_ctrl dut (
      .clk(clk), .rst(rst), .pc(pc), .stall(stall),
      .jump_req(jump_req), .jump_target(jump_target),
      .branch_req(branch_req), .branch_target(branch_target),
      .irq_req(irq_req), .iret_req(iret_req),
      .load_pc(load_pc), .pc_in(pc_in), .pc_en(pc_en), .flush(flush),
      .irq_ack(irq_ack), .in_isr(in_isr), .epc(epc)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, want finish");
      $fatal(1);
   end

   typedef struct {
      logic [15:0] pc;
      logic        stall, jump, branch, irq, iret;
      logic [15:0] jt, bt;
   } stim_t;

   typedef struct {
      logic        jump, branch, stall, iret;
      logic [15:0] jt, bt;
      logic        e_load;
      logic [15:0] e_pc_in;
      logic        e_en, e_flush;
   } vec_t;

   // Behavioural model: boot pending flag, interrupt-entry countdown, isr flag, epc.
   bit          m_boot;
   int          m_entry;
   logic        m_load, m_en, m_flush, m_ack, m_isr;
   logic [15:0] m_pc_in, m_epc;

   task automatic model_reset();
      m_boot = 1; m_entry = 0; m_isr = 0; m_epc = '0;
      m_load = 0; m_en = 0; m_flush = 0; m_ack = 0; m_pc_in = RVEC;
   endtask

   task automatic model_step(input stim_t s);
      m_load = 0; m_en = 0; m_flush = 0; m_ack = 0;
      if (m_boot) begin
         m_load = 1; m_pc_in = RVEC; m_boot = 0;
      end else if (m_entry == 2) begin
         m_load = 1; m_pc_in = IVEC; m_ack = 1; m_isr = 1; m_entry = 1;
      end else if (m_entry == 1) begin
         m_en = 1; m_entry = 0;
      end else if (IRQ_EN && s.irq && !m_isr) begin
         m_flush = 1; m_entry = 2;
         m_epc = s.jump ? s.jt : (s.branch ? s.bt : s.pc);
      end else if (IRQ_EN && s.iret && m_isr) begin
         m_load = 1; m_flush = 1; m_pc_in = m_epc; m_isr = 0;
      end else if (s.jump) begin
         m_load = 1; m_flush = 1; m_pc_in = s.jt;
      end else if (s.branch) begin
         m_load = 1; m_flush = 1; m_pc_in = s.bt;
      end else if (!s.stall) begin
         m_en = 1;
      end
   endtask

   task automatic check_model(input string name);
      vectors++;
      if ({load_pc, pc_in, pc_en, flush, irq_ack, in_isr, epc} !==
          {m_load, m_pc_in, m_en, m_flush, m_ack, m_isr, m_epc}) begin
         miscompares++;
         $display("FAIL %s: got load=%0b pc_in=%h en=%0b flush=%0b ack=%0b isr=%0b epc=%h, want load=%0b pc_in=%h en=%0b flush=%0b ack=%0b isr=%0b epc=%h",
                  name, load_pc, pc_in, pc_en, flush, irq_ack, in_isr, epc,
                  m_load, m_pc_in, m_en, m_flush, m_ack, m_isr, m_epc);
      end
   endtask

   task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Called at a falling edge; returns at the following falling edge.
   task automatic apply(input stim_t s);
      pc = s.pc; stall = s.stall; jump_req = s.jump; branch_req = s.branch;
      jump_target = s.jt; branch_target = s.bt; irq_req = s.irq; iret_req = s.iret;
      @(posedge clk);
      model_step(s);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 0;
      #1;
      model_reset();
      check_model("reset_immediate");
      #1;
      rst = 1;
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{pc: 16'h0, stall: 0, jump: 0, branch: 0, irq: 0, iret: 0, jt: 16'h0, bt: 16'h0};
      return s;
   endfunction

   vec_t tbl[$];
   stim_t s;

   initial begin
      tbl.push_back('{0,0,0,0, 16'h0000,16'h0000, 1,16'h0000,0,0}); // boot load
      tbl.push_back('{0,0,0,0, 16'h0000,16'h0000, 0,16'h0000,1,0});
      tbl.push_back('{1,1,0,0, 16'h1234,16'hff33, 1,16'h1234,0,1}); // jump beats branch
      tbl.push_back('{0,0,0,0, 16'h0000,16'h0000, 0,16'h1234,1,0});
      for (int k = 0; k < 5; k++)
         tbl.push_back('{0,0,1,0, 16'h0000,16'h0000, 0,16'h1234,0,0});
      tbl.push_back('{0,1,1,0, 16'h0000,16'h0abc, 1,16'h0abc,0,1}); // branch over stall
      tbl.push_back('{0,1,0,0, 16'h0000,16'h0100, 1,16'h0100,0,1});
      tbl.push_back('{0,0,1,0, 16'h0000,16'h0000, 0,16'h0100,0,0});
      tbl.push_back('{1,0,1,0, 16'h2222,16'h0000, 1,16'h2222,0,1});
      tbl.push_back('{0,0,0,1, 16'h0000,16'h0000, 0,16'h2222,1,0}); // iret outside isr

      @(negedge clk);
      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         s = idle();
         s.jump = tbl[i].jump; s.branch = tbl[i].branch; s.stall = tbl[i].stall;
         s.iret = tbl[i].iret; s.jt = tbl[i].jt; s.bt = tbl[i].bt;
         apply(s);
         vectors++;
         if ({load_pc, pc_in, pc_en, flush, irq_ack} !==
             {tbl[i].e_load, tbl[i].e_pc_in, tbl[i].e_en, tbl[i].e_flush, 1'b0}) begin
            miscompares++;
            $display("FAIL table[%0d]: got load=%0b pc_in=%h en=%0b flush=%0b ack=%0b, want load=%0b pc_in=%h en=%0b flush=%0b ack=0",
                     i, load_pc, pc_in, pc_en, flush, irq_ack,
                     tbl[i].e_load, tbl[i].e_pc_in, tbl[i].e_en, tbl[i].e_flush);
         end
      end

      // Boot cycle ignores a request; the next cycle's redirect loads again.
      do_reset();
      s = idle(); s.jump = 1; s.jt = 16'h3000;
      apply(s); check_model("boot_ignores_jump");
      apply(s); check_model("boot_then_redirect");
      check_val("boot_then_redirect_pc", pc_in, 16'h3000);

      // Interrupt request: taken only in the IRQ-enabled build.
      s = idle(); s.pc = 16'h0042; s.irq = 1;
      apply(s); check_model("irq_entry");
`ifdef IF_CTRL_IRQ_EN
      check_val("irq_entry_epc", epc, 16'h0042);
      check_val("irq_entry_flush", {15'd0, flush}, 16'h1);
      s = idle(); s.jump = 1; s.jt = 16'h5555; s.stall = 1;
      apply(s); check_model("irq_vector");
      check_val("irq_vector_pc", pc_in, IVEC);
      check_val("irq_vector_ack", {14'd0, irq_ack, in_isr}, 16'h3);
      apply(idle()); check_model("irq_resume");
      s = idle(); s.irq = 1;
      apply(s); check_model("irq_nested_ignored");
      s = idle(); s.iret = 1;
      apply(s); check_model("iret");
      check_val("iret_pc", pc_in, 16'h0042);
      s = idle(); s.irq = 1; s.branch = 1; s.bt = 16'h0200; s.pc = 16'h0077;
      apply(s); check_model("irq_with_branch");
      check_val("irq_with_branch_epc", epc, 16'h0200);
      // Reset while the entry is in flight: no acknowledge, boot follows.
      do_reset();
      check_val("rst_mid_entry_ack", {15'd0, irq_ack}, 16'h0);
      apply(idle()); check_model("rst_mid_entry_boot");
      check_val("rst_mid_entry_no_ack", {15'd0, irq_ack}, 16'h0);
`else
      check_val("irq_ignored_ack", {15'd0, irq_ack}, 16'h0);
      s = idle(); s.iret = 1;
      apply(s); check_model("iret_ignored");
`endif

      for (int i = 0; i < 800; i++) begin
         s.pc = 16'($urandom);
         s.jt = 16'($urandom);
         s.bt = 16'($urandom);
         s.stall = ($urandom_range(0, 3) == 0);
         s.jump = ($urandom_range(0, 7) == 0);
         s.branch = ($urandom_range(0, 5) == 0);
         s.irq = ($urandom_range(0, 9) == 0);
         s.iret = ($urandom_range(0, 5) == 0);
         if (i % 200 == 137) do_reset();
         else begin
            apply(s);
            check_model("random");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/if_ctrl.md
IF_CTRL -- requirements
Module: if_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 16'h0000, SHALL be the PC loaded after reset.
REQ-002 Parameter IRQ_VEC, default 16'h0010, SHALL be the interrupt handler entry PC.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 pc  input  16  SHALL be the current PC from the IF stage.
REQ-006 stall  input  1  SHALL be the downstream hold request (freeze fetch).
REQ-007 jump_req / jump_target  input  1/16  SHALL be the unconditional redirect request and its target.
REQ-008 branch_req / branch_target  input  1/16  SHALL be the taken-branch redirect request and its target.
REQ-009 irq_req  input  1  SHALL be the level-sensitive interrupt request.
REQ-010 iret_req  input  1  SHALL be the return-from-interrupt request.
REQ-011 load_pc / pc_in  output  1/16  SHALL be the IF-stage PC load strobe and load value.
REQ-012 pc_en  output  1  SHALL be asserted to let the IF stage advance sequentially.
REQ-013 flush  output  1  SHALL be asserted to squash the in-flight fetched instruction.
REQ-014 irq_ack / in_isr / epc  output  1/1/16  SHALL be the interrupt acknowledge, handler-active flag and saved return PC.

Function
REQ-015 All outputs SHALL be registered; every request sampled at edge N SHALL produce its response during cycle N+1 (latency 1).
REQ-016 FSM states SHALL be BOOT, RUN, IRQ_SAVE, IRQ_JUMP.
REQ-017 BOOT: load_pc=1, pc_in=RESET_VEC, pc_en=0 for exactly one cycle, then RUN.
REQ-018 RUN priority SHALL be irq (when enabled, not in_isr) > iret_req > jump_req > branch_req > stall > sequential.
REQ-019 RUN redirect (jump, branch, iret): load_pc=1, flush=1, pc_en=0 for one cycle; pc_in = jump_target, branch_target or epc respectively; iret also clears in_isr.
REQ-020 A redirect SHALL override a simultaneous stall; requests are not queued, and a request not granted in its cycle is dropped.
REQ-021 RUN with stall=1 and no redirect: load_pc=0, pc_en=0, flush=0; otherwise pc_en=1.
REQ-022 RUN with irq_req=1, in_isr=0: go to IRQ_SAVE; capture epc <= pc; assert flush=1, pc_en=0.
REQ-023 If jump_req or branch_req coincides with irq entry, epc SHALL capture the winning redirect target instead of pc, so the redirect is not lost.
REQ-024 IRQ_SAVE -> IRQ_JUMP unconditionally; IRQ_JUMP asserts load_pc=1, pc_in=IRQ_VEC, irq_ack=1 for one cycle and sets in_isr, then RUN.
REQ-025 stall, jump_req, branch_req, iret_req and irq_req SHALL be ignored in IRQ_SAVE and IRQ_JUMP.
REQ-026 irq_req SHALL be ignored while in_isr=1 (no nesting); iret_req SHALL be ignored while in_isr=0.
REQ-027 load_pc SHALL never be high for two consecutive cycles except BOOT followed immediately by a RUN redirect.

Reset
REQ-028 rst=0 SHALL immediately force state=BOOT, load_pc=0, pc_in=RESET_VEC, pc_en=0, flush=0, irq_ack=0, in_isr=0, epc=16'h0000.
REQ-029 Reset asserted mid-interrupt-entry SHALL abandon the entry with no irq_ack issued.
REQ-030 After rst deasserts, the first rising edge SHALL execute the BOOT cycle.

Configuration
REQ-031 Macro IF_CTRL_IRQ_EN defined: interrupt logic per REQ-022..REQ-026.
REQ-032 IF_CTRL_IRQ_EN undefined: IRQ_SAVE/IRQ_JUMP and epc storage removed; irq_req and iret_req ignored; irq_ack, in_isr and epc tied to 0.

Structure
REQ-033 Shared package if_pkg SHALL hold the FSM state encoding (2-bit), default RESET_VEC/IRQ_VEC constants and PC width (16).
REQ-034 Single module; no sub-module. Redirect priority mux SHALL be combinational, registered once at the outputs.

Verification
REQ-035 Reset release -> cycle 1: load_pc=1, pc_in=16'h0000; cycle 2+: pc_en=1.
REQ-036 RUN, branch_req=1, branch_target=16'hff33, same cycle jump_req=1, jump_target=16'h1234 -> next cycle load_pc=1, pc_in=16'h1234, flush=1.
REQ-037 stall=1 for 5 cycles -> pc_en=0, load_pc=0 throughout; stall with branch_req -> branch taken.
REQ-038 pc=16'h0042, irq_req=1 -> epc=16'h0042, flush; next cycle load_pc=1, pc_in=16'h0010, irq_ack=1, in_isr=1; later iret_req -> pc_in=16'h0042, in_isr=0.
REQ-039 irq_req with branch_target=16'h0200 in the same cycle -> epc=16'h0200; second irq while in_isr -> no response.
REQ-040 rst pulsed low during IRQ_SAVE -> outputs reset immediately, no irq_ack, BOOT cycle follows.
